// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the issue hazard controller: GPR index width,
//   scoreboard counter width, and the CSR one-hot bit assignments used on
//   id_csr_ren / id_csr_wen / wb_csr_wen.
package hazard_ctrl_pkg;

  localparam int GPR_IDX_W = 5;
  localparam int CNT_W     = 2;
  localparam int NUM_GPR   = 32;
  localparam int NUM_CSR   = 4;
  localparam int INFL_W    = 3;
  localparam int FLUSH_W   = 3;

  // Bit position of each tracked CSR inside the 4-bit one-hot vectors.
  typedef enum logic [1:0] {
    CSR_MEPC    = 2'd0,
    CSR_MCAUSE  = 2'd1,
    CSR_MSTATUS = 2'd2,
    CSR_MTVEC   = 2'd3
  } csr_idx_e;

  // Architectural addresses matching each one-hot bit.
  localparam logic [11:0] CSR_ADDR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_ADDR_MTVEC   = 12'h305;

  function automatic logic [NUM_CSR-1:0] csr_onehot(input csr_idx_e idx);
    logic [NUM_CSR-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sb_counter.sv
// sb_counter
//   One scoreboard entry: a CNT_W-bit pending-write counter.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     i_inc     - an instruction writing this resource issued
//     i_dec     - a write to this resource retired
//     o_nz      - counter nonzero (resource has a pending write)
//     o_full    - counter at maximum (no further writer may issue)
//     o_uflow   - retire seen while counter already 0 (single-cycle pulse)
module sb_counter
  import hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_nz,
  output logic o_full,
  output logic o_uflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  // Simultaneous inc and dec cancel; both ends saturate instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_nz    = (r_cnt != '0);
  assign o_full  = (r_cnt == CNT_MAX);
  assign o_uflow = i_dec & ~i_inc & (r_cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   In-order issue hazard controller. A per-register scoreboard (31 GPRs,
//   4 CSRs) plus an in-flight writer count decide whether the instruction
//   in decode may issue; a redirect from execute squashes decode for
//   FLUSH_CYC further cycles.
//   Ports:
//     clk, rst                       - clock, asynchronous active-high reset
//     id_valid, id_rs1/2, id_rs1/2_used, id_rd, id_rd_wen,
//     id_csr_ren, id_csr_wen         - decode-stage instruction
//     issue_fire                     - decode instruction issues this cycle
//     wb_valid, wb_rd, wb_rd_wen, wb_csr_wen - writeback retire
//     ex_redirect                    - control transfer resolved in execute
//     pipe_stop                      - stall fetch/decode
//     inst_clear                     - squash decode
//     sb_err                         - sticky scoreboard underflow
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC    = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [GPR_IDX_W-1:0] id_rs1,
  input  logic [GPR_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [GPR_IDX_W-1:0] id_rd,
  input  logic                 id_rd_wen,
  input  logic [NUM_CSR-1:0]   id_csr_ren,
  input  logic [NUM_CSR-1:0]   id_csr_wen,
  output logic                 issue_fire,
  input  logic                 wb_valid,
  input  logic [GPR_IDX_W-1:0] wb_rd,
  input  logic                 wb_rd_wen,
  input  logic [NUM_CSR-1:0]   wb_csr_wen,
  input  logic                 ex_redirect,
  output logic                 pipe_stop,
  output logic                 inst_clear,
  output logic                 sb_err
);

  localparam logic [INFL_W-1:0]  INFL_MAX   = INFL_W'(MAX_INFLIGHT);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYC);

  logic [INFL_W-1:0]  r_inflight;
  logic [FLUSH_W-1:0] r_flush_cnt;
  logic               r_sb_err;

  logic [NUM_GPR-1:0] w_gpr_nz;
  logic [NUM_GPR-1:0] w_gpr_full;
  logic [NUM_GPR-1:1] w_gpr_inc;
  logic [NUM_GPR-1:1] w_gpr_dec;
  logic [NUM_GPR-1:1] w_gpr_uflow;
  logic [NUM_CSR-1:0] w_csr_nz;
  logic [NUM_CSR-1:0] w_csr_full;
  logic [NUM_CSR-1:0] w_csr_inc;
  logic [NUM_CSR-1:0] w_csr_dec;
  logic [NUM_CSR-1:0] w_csr_uflow;

  logic w_id_rd_wr;
  logic w_id_writes;
  logic w_wb_rd_wr;
  logic w_wb_writes;
  logic w_raw;
  logic w_struct;
  logic w_flushing;
  logic w_blocked;
  logic w_infl_inc;
  logic w_infl_dec;
  logic w_infl_uflow;

  // x0 is hardwired: never pending, never full.
  assign w_gpr_nz[0]   = 1'b0;
  assign w_gpr_full[0] = 1'b0;

  for (genvar g = 1; g < NUM_GPR; g++) begin : g_gpr
    assign w_gpr_inc[g] = issue_fire & id_rd_wen & (id_rd == GPR_IDX_W'(g));
    assign w_gpr_dec[g] = wb_valid & wb_rd_wen & (wb_rd == GPR_IDX_W'(g));
    sb_counter u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_gpr_inc[g]),
      .i_dec   (w_gpr_dec[g]),
      .o_nz    (w_gpr_nz[g]),
      .o_full  (w_gpr_full[g]),
      .o_uflow (w_gpr_uflow[g])
    );
  end

  for (genvar c = 0; c < NUM_CSR; c++) begin : g_csr
    assign w_csr_inc[c] = issue_fire & id_csr_wen[c];
    assign w_csr_dec[c] = wb_valid & wb_csr_wen[c];
    sb_counter u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_csr_inc[c]),
      .i_dec   (w_csr_dec[c]),
      .o_nz    (w_csr_nz[c]),
      .o_full  (w_csr_full[c]),
      .o_uflow (w_csr_uflow[c])
    );
  end

  // Hazard evaluation uses registered scoreboard state only, so a retire
  // releases its dependants one cycle later (no writeback bypass).
  assign w_id_rd_wr  = id_rd_wen & (id_rd != '0);
  assign w_id_writes = w_id_rd_wr | (|id_csr_wen);
  assign w_wb_rd_wr  = wb_rd_wen & (wb_rd != '0);
  assign w_wb_writes = w_wb_rd_wr | (|wb_csr_wen);

  assign w_raw = (id_rs1_used & w_gpr_nz[id_rs1])
               | (id_rs2_used & w_gpr_nz[id_rs2])
               | (|(id_csr_ren & w_csr_nz));

  assign w_struct = w_id_writes &
                    ((r_inflight == INFL_MAX)
                   | (w_id_rd_wr & w_gpr_full[id_rd])
                   | (|(id_csr_wen & w_csr_full)));

  assign w_flushing = (r_flush_cnt != '0);
  assign w_blocked  = ex_redirect | w_flushing | w_raw | w_struct;

  // Outputs are forced low during reset so nothing issues or squashes
  // while the scoreboard is being cleared.
  assign pipe_stop  = ~rst & id_valid & w_blocked;
  assign issue_fire = ~rst & id_valid & ~w_blocked;
  assign inst_clear = ~rst & (ex_redirect | w_flushing);
  assign sb_err     = r_sb_err;

  // An instruction writing both a GPR and a CSR counts as one in-flight
  // writer, matching the single retire it produces.
  assign w_infl_inc   = issue_fire & w_id_writes;
  assign w_infl_dec   = wb_valid & w_wb_writes;
  assign w_infl_uflow = w_infl_dec & ~w_infl_inc & (r_inflight == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (w_infl_inc && !w_infl_dec) begin
      if (r_inflight != '1) r_inflight <= r_inflight + 1'b1;
    end else if (w_infl_dec && !w_infl_inc) begin
      if (r_inflight != '0) r_inflight <= r_inflight - 1'b1;
    end
  end

  // A redirect (re)loads the full squash window even mid-flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else if (ex_redirect) begin
      r_flush_cnt <= FLUSH_LOAD;
    end else if (w_flushing) begin
      r_flush_cnt <= r_flush_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_err <= 1'b0;
    end else if ((|w_gpr_uflow) || (|w_csr_uflow) || w_infl_uflow) begin
      r_sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed, table-driven bench for hazard_ctrl (default parameters:
//   FLUSH_CYC=2, MAX_INFLIGHT=4). Each table row is one clock cycle of
//   decode/writeback/redirect inputs with the outputs expected in that
//   cycle; reset and redirect timing are driven as hand-written sequences.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_rd_wen;
  logic [3:0] id_csr_ren;
  logic [3:0] id_csr_wen;
  logic       issue_fire;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       wb_rd_wen;
  logic [3:0] wb_csr_wen;
  logic       ex_redirect;
  logic       pipe_stop;
  logic       inst_clear;
  logic       sb_err;

  int n_checks;
  int n_fail;

  hazard_ctrl #(
    .FLUSH_CYC    (2),
    .MAX_INFLIGHT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_rd_wen   (id_rd_wen),
    .id_csr_ren  (id_csr_ren),
    .id_csr_wen  (id_csr_wen),
    .issue_fire  (issue_fire),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_rd_wen   (wb_rd_wen),
    .wb_csr_wen  (wb_csr_wen),
    .ex_redirect (ex_redirect),
    .pipe_stop   (pipe_stop),
    .inst_clear  (inst_clear),
    .sb_err      (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       idv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wen;
    logic [3:0] cren;
    logic [3:0] cwen;
    logic       wbv;
    logic [4:0] wbrd;
    logic       wbwen;
    logic [3:0] wbcsr;
    logic       redir;
    logic       e_stop;
    logic       e_fire;
    logic       e_clr;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic idv,
                              logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic wen, logic [3:0] cren, logic [3:0] cwen,
                              logic wbv, logic [4:0] wbrd, logic wbwen, logic [3:0] wbcsr,
                              logic redir, logic es, logic ef, logic ec, logic ee);
    vec_t v;
    v.name = n;   v.idv = idv;
    v.rs1 = rs1;  v.u1 = u1;    v.rs2 = rs2;  v.u2 = u2;
    v.rd = rd;    v.wen = wen;  v.cren = cren; v.cwen = cwen;
    v.wbv = wbv;  v.wbrd = wbrd; v.wbwen = wbwen; v.wbcsr = wbcsr;
    v.redir = redir;
    v.e_stop = es; v.e_fire = ef; v.e_clr = ec; v.e_err = ee;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string nm, input logic es, input logic ef,
                            input logic ec, input logic ee);
    check({nm, ".pipe_stop"},  pipe_stop,  es);
    check({nm, ".issue_fire"}, issue_fire, ef);
    check({nm, ".inst_clear"}, inst_clear, ec);
    check({nm, ".sb_err"},     sb_err,     ee);
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.idv;   id_rs1 = v.rs1;   id_rs1_used = v.u1;
    id_rs2 = v.rs2;     id_rs2_used = v.u2;
    id_rd = v.rd;       id_rd_wen = v.wen;
    id_csr_ren = v.cren; id_csr_wen = v.cwen;
    wb_valid = v.wbv;   wb_rd = v.wbrd;   wb_rd_wen = v.wbwen; wb_csr_wen = v.wbcsr;
    ex_redirect = v.redir;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_wen = 0; id_csr_ren = 0; id_csr_wen = 0;
    wb_valid = 0; wb_rd = 0; wb_rd_wen = 0; wb_csr_wen = 0; ex_redirect = 0;
  endtask

  // Hard stop if something prevents the bench from finishing normally.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //  name            idv rs1 u1 rs2 u2 rd wen cren     cwen     wbv wbrd wbwen wbcsr  rd  stp fir clr err
    add("idle",          0,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 0, 0, 0);
    add("x0_src",        1,  0, 1,  0, 1,  0, 0, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    // RAW on x5, released the cycle after its retire
    add("iss_x5",        1,  0, 0,  0, 0,  5, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("raw_x5_a",      1,  5, 1,  0, 0,  6, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 1, 0, 0, 0);
    add("raw_x5_b",      1,  5, 1,  0, 0,  6, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 1, 0, 0, 0);
    add("raw_x5_wb",     1,  5, 1,  0, 0,  6, 1, 4'b0000, 4'b0000, 1,  5,  1, 4'b0000, 0, 1, 0, 0, 0);
    add("raw_x5_go",     1,  5, 1,  0, 0,  6, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("ret_x6",        0,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b0000, 1,  6,  1, 4'b0000, 0, 0, 0, 0, 0);
    add("rs2_x6_free",   1,  0, 0,  6, 1,  0, 0, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    // in-flight limit
    add("wr_x1",         1,  0, 0,  0, 0,  1, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("wr_x2",         1,  0, 0,  0, 0,  2, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("wr_x3",         1,  0, 0,  0, 0,  3, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("wr_x4",         1,  0, 0,  0, 0,  4, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("full_wr_x5",    1,  0, 0,  0, 0,  5, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 1, 0, 0, 0);
    add("full_nowrite",  1,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("full_raw_x3",   1,  3, 1,  0, 0,  0, 0, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 1, 0, 0, 0);
    add("full_wr_x5_wb", 1,  0, 0,  0, 0,  5, 1, 4'b0000, 4'b0000, 1,  1,  1, 4'b0000, 0, 1, 0, 0, 0);
    add("wr_x5_go",      1,  0, 0,  0, 0,  5, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("ret_x2",        0,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b0000, 1,  2,  1, 4'b0000, 0, 0, 0, 0, 0);
    add("ret_x3",        0,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b0000, 1,  3,  1, 4'b0000, 0, 0, 0, 0, 0);
    add("ret_x4",        0,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b0000, 1,  4,  1, 4'b0000, 0, 0, 0, 0, 0);
    add("ret_x5",        0,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b0000, 1,  5,  1, 4'b0000, 0, 0, 0, 0, 0);
    // CSR RAW on mtvec (bit 3); mepc (bit 0) unaffected
    add("csrw_mtvec",    1,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b1000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("csrr_mepc",     1,  0, 0,  0, 0,  0, 0, 4'b0001, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("csrr_mtvec_a",  1,  0, 0,  0, 0,  0, 0, 4'b1000, 4'b0000, 0,  0,  0, 4'b0000, 0, 1, 0, 0, 0);
    add("csrr_mtvec_wb", 1,  0, 0,  0, 0,  0, 0, 4'b1000, 4'b0000, 1,  0,  0, 4'b1000, 0, 1, 0, 0, 0);
    add("csrr_mtvec_go", 1,  0, 0,  0, 0,  0, 0, 4'b1000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    // per-register counter saturation at 3
    add("x10_w1",        1,  0, 0,  0, 0, 10, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("x10_w2",        1,  0, 0,  0, 0, 10, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("x10_w3",        1,  0, 0,  0, 0, 10, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("x10_full",      1,  0, 0,  0, 0, 10, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 1, 0, 0, 0);
    add("x10_full_wb",   1,  0, 0,  0, 0, 10, 1, 4'b0000, 4'b0000, 1, 10,  1, 4'b0000, 0, 1, 0, 0, 0);
    add("x10_w_go",      1,  0, 0,  0, 0, 10, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("ret_x10_a",     0,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b0000, 1, 10,  1, 4'b0000, 0, 0, 0, 0, 0);
    add("ret_x10_b",     0,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b0000, 1, 10,  1, 4'b0000, 0, 0, 0, 0, 0);
    add("ret_x10_c",     0,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b0000, 1, 10,  1, 4'b0000, 0, 0, 0, 0, 0);
    // same-cycle issue/retire on x7, then underflow on x9
    add("iss_x7",        1,  0, 0,  0, 0,  7, 1, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("x7_iss_ret",    1,  0, 0,  0, 0,  7, 1, 4'b0000, 4'b0000, 1,  7,  1, 4'b0000, 0, 0, 1, 0, 0);
    add("x7_pend1_wb",   1,  7, 1,  0, 0,  0, 0, 4'b0000, 4'b0000, 1,  7,  1, 4'b0000, 0, 1, 0, 0, 0);
    add("x7_free",       1,  7, 1,  0, 0,  0, 0, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 0);
    add("ret_x9_uflow",  0,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b0000, 1,  9,  1, 4'b0000, 0, 0, 0, 0, 0);
    add("err_sticky",    0,  0, 0,  0, 0,  0, 0, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 0, 0, 1);
    add("err_sticky_2",  1,  0, 1,  0, 1,  0, 0, 4'b0000, 4'b0000, 0,  0,  0, 4'b0000, 0, 0, 1, 0, 1);

    // Reset asserted from time 0 with an active decode and redirect.
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    id_valid = 1; ex_redirect = 1;
    #1;
    check_outs("in_reset", 0, 0, 0, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_outs(vecs[i].name, vecs[i].e_stop, vecs[i].e_fire, vecs[i].e_clr, vecs[i].e_err);
    end

    // Reset mid-operation: outstanding x12 write and sticky error discarded.
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rd = 12; id_rd_wen = 1;
    #1;
    check_outs("pre_rst_x12", 0, 1, 0, 1);
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rs1 = 12; id_rs1_used = 1; ex_redirect = 1;
    #2;
    rst = 1'b1;
    #1;
    check_outs("rst_async", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_outs("rst_held", 0, 0, 0, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    id_valid = 1; id_rs1 = 12; id_rs1_used = 1;
    #1;
    check_outs("post_rst_x12", 0, 1, 0, 0);

    // Redirect pulse at cycle 10: squash 10..12, issue resumes at 13.
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      idle_inputs();
      id_valid = 1; id_rs1 = 0; id_rs1_used = 1;
      ex_redirect = (k == 10);
      #1;
      if (k >= 10 && k <= 12)
        check_outs($sformatf("flush_c%0d", k), 1, 0, 1, 0);
      else
        check_outs($sformatf("flush_c%0d", k), 0, 1, 0, 0);
    end

    // Redirect during a flush reloads the window; no decode at k=1.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      idle_inputs();
      id_valid    = (k != 1);
      ex_redirect = (k == 0) || (k == 2);
      #1;
      if (k == 1)
        check_outs($sformatf("reload_c%0d", k), 0, 0, 1, 0);
      else if (k <= 4)
        check_outs($sformatf("reload_c%0d", k), 1, 0, 1, 0);
      else
        check_outs($sformatf("reload_c%0d", k), 0, 1, 0, 0);
    end

    @(negedge clk);
    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
